// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 stream arbiter and mux control stage.
//   SRC_A / SRC_B : encoding of the source tag and of the last-grant register.
//   LAST_RST      : last-grant value after reset. It points at B so that A wins
//                   the first contention.
package mux_pkg;

   localparam logic SRC_A    = 1'b0;
   localparam logic SRC_B    = 1'b1;
   localparam logic LAST_RST = SRC_B;

endpackage : mux_pkg

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic (purely combinational).
// Ports:
//   req_a, req_b : request from stream A / stream B
//   last         : source of the most recent transfer (SRC_A / SRC_B)
//   gnt_a, gnt_b : one-hot-or-zero grant
// A lone requester is always granted. When both request, the grant goes to
// whichever side did not win the previous transfer.
module rr_arb2
   import mux_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic last,
   output logic gnt_a,
   output logic gnt_b
);

   assign gnt_a = req_a & (~req_b | (last == SRC_B));
   assign gnt_b = req_b & (~req_a | (last == SRC_A));

endmodule : rr_arb2

// File: rtl/mux2to1_stream_arb.sv
// Upstream control stage for the 2:1 mux datapath. It arbitrates two
// valid/ready streams round-robin, drives the mux select and registers the
// selected word into a single-entry output stage tagged with its source.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   a_data/a_valid/a_ready    : input stream A
//   b_data/b_valid/b_ready    : input stream B
//   sel                       : combinational mux select (0=A, 1=B)
//   y_data/y_valid/y_ready    : registered output stream
//   y_src                     : source of y_data (0=A, 1=B)
module mux2to1_stream_arb
   import mux_pkg::*;
#(
   parameter int W = 8
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] a_data,
   input  logic         a_valid,
   output logic         a_ready,
   input  logic [W-1:0] b_data,
   input  logic         b_valid,
   output logic         b_ready,
   output logic         sel,
   output logic [W-1:0] y_data,
   output logic         y_valid,
   input  logic         y_ready,
   output logic         y_src
);

   logic         y_valid_q, y_valid_d;
   logic [W-1:0] y_data_q,  y_data_d;
   logic         y_src_q,   y_src_d;
   logic         last_q,    last_d;

   logic         load;
   logic         gnt_a, gnt_b;
   logic         xfer;
   logic [W-1:0] mux_c;

   // The output register can take a word when empty or when its current word
   // leaves this cycle; this is what gives full throughput with no bubble.
   assign load = ~y_valid_q | y_ready;

   rr_arb2 u_arb (
      .req_a (a_valid),
      .req_b (b_valid),
      .last  (last_q),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b)
   );

   assign sel     = gnt_b;
   assign a_ready = load & gnt_a;
   assign b_ready = load & gnt_b;
   assign xfer    = load & (gnt_a | gnt_b);

   // Gate-level mux form c = ~s&a | s&b, one bit at a time.
   for (genvar i = 0; i < W; i++) begin : g_mux
      assign mux_c[i] = (~sel & a_data[i]) | (sel & b_data[i]);
   end

   always_comb begin
      y_valid_d = y_valid_q;
      y_data_d  = y_data_q;
      y_src_d   = y_src_q;
      last_d    = last_q;
      if (load) begin
         if (xfer) begin
            y_valid_d = 1'b1;
            y_data_d  = mux_c;
            y_src_d   = sel;
            last_d    = sel;
         end else begin
            // Data and tag are kept so the bus never shows unqualified values.
            y_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_valid_q <= 1'b0;
         y_data_q  <= '0;
         y_src_q   <= SRC_A;
         last_q    <= LAST_RST;
      end else begin
         y_valid_q <= y_valid_d;
         y_data_q  <= y_data_d;
         y_src_q   <= y_src_d;
         last_q    <= last_d;
      end
   end

   assign y_valid = y_valid_q;
   assign y_data  = y_data_q;
   assign y_src   = y_src_q;

endmodule : mux2to1_stream_arb

// File: tb/tb_mux2to1_stream_arb.sv
module tb_mux2to1_stream_arb;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a_data, b_data;
   logic         a_valid, b_valid, y_ready;
   logic         a_ready, b_ready, sel, y_valid, y_src;
   logic [W-1:0] y_data;

   int checks = 0;
   int errors = 0;

   mux2to1_stream_arb #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .a_data  (a_data),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .b_data  (b_data),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .sel     (sel),
      .y_data  (y_data),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_src   (y_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one-entry output buffer plus "who was served last".
   bit           m_ok   = 1'b0;
   bit           m_full;
   logic [W-1:0] m_data;
   bit           m_src;
   bit           m_last;

   // Which side gets served now: -1 none, 0 A, 1 B.
   function automatic int m_winner();
      if (a_valid && b_valid) return (m_last == 1'b0) ? 1 : 0;
      if (a_valid) return 0;
      if (b_valid) return 1;
      return -1;
   endfunction

   function automatic bit m_room();
      return !m_full || y_ready;
   endfunction

   always @(posedge clk) begin
      int w;
      w = m_winner();
      if (rst) begin
         m_ok   <= 1'b1;
         m_full <= 1'b0;
         m_data <= '0;
         m_src  <= 1'b0;
         m_last <= 1'b1;
      end else if (m_ok && m_room()) begin
         if (w >= 0) begin
            m_full <= 1'b1;
            m_data <= (w == 1) ? b_data : a_data;
            m_src  <= (w == 1);
            m_last <= (w == 1);
         end else begin
            m_full <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      int w;
      if (m_ok) begin
         w = m_winner();
         chk("m_a_ready", {31'd0, a_ready}, {31'd0, m_room() && w == 0});
         chk("m_b_ready", {31'd0, b_ready}, {31'd0, m_room() && w == 1});
         chk("m_sel",     {31'd0, sel},     {31'd0, w == 1});
         chk("m_y_valid", {31'd0, y_valid}, {31'd0, m_full});
         chk("m_y_data",  {24'd0, y_data},  {24'd0, m_data});
         chk("m_y_src",   {31'd0, y_src},   {31'd0, m_src});
      end
   end

   // Inputs change 1 ns after the rising edge; callers check 2 ns later.
   task automatic step(input bit av, input logic [W-1:0] ad, input bit bv,
                       input logic [W-1:0] bd, input bit yr, input bit r);
      @(posedge clk);
      #1;
      a_valid = av; a_data = ad;
      b_valid = bv; b_data = bd;
      y_ready = yr; rst = r;
      #2;
   endtask

   initial begin
      logic [W-1:0] hd;
      logic         hs;
      rst = 1'b1; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; y_ready = 0;
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      // Load one word and hold it, then reset mid-stream.
      step(1, 8'h55, 0, 0, 0, 0);
      step(1, 8'h66, 1, 8'h77, 0, 1);
      chk("pre_rst_y_valid", {31'd0, y_valid}, 32'd1);
      chk("pre_rst_y_data", {24'd0, y_data}, 32'h55);

      // First cycle after reset, both valid: A wins. Then alternate.
      step(1, 8'hA0, 1, 8'hB0, 1, 0);
      chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
      chk("rst_y_data", {24'd0, y_data}, 32'd0);
      chk("rst_y_src", {31'd0, y_src}, 32'd0);
      chk("rst_first_sel", {31'd0, sel}, 32'd0);
      chk("rst_first_a_ready", {31'd0, a_ready}, 32'd1);
      for (int n = 1; n <= 5; n++) begin
         step(1, 8'hA0 + n[7:0], 1, 8'hB0 + n[7:0], 1, 0);
         chk("rr_y_valid", {31'd0, y_valid}, 32'd1);
         chk("rr_y_data", {24'd0, y_data},
             ((n - 1) % 2 == 0) ? 32'hA0 + n - 1 : 32'hB0 + n - 1);
         chk("rr_y_src", {31'd0, y_src}, ((n - 1) % 2 == 0) ? 32'd0 : 32'd1);
      end

      // Backpressure for three cycles with both inputs valid.
      step(1, 8'hC0, 1, 8'hD0, 0, 0);
      hd = y_data; hs = y_src;
      chk("bp_y_data0", {24'd0, y_data}, 32'hB5);
      for (int n = 0; n < 3; n++) begin
         if (n > 0) step(1, 8'hC0, 1, 8'hD0, 0, 0);
         chk("bp_a_ready", {31'd0, a_ready}, 32'd0);
         chk("bp_b_ready", {31'd0, b_ready}, 32'd0);
         chk("bp_y_data", {24'd0, y_data}, {24'd0, hd});
         chk("bp_y_src", {31'd0, y_src}, {31'd0, hs});
      end
      step(1, 8'hC0, 1, 8'hD0, 1, 0);
      chk("bp_release_a_ready", {31'd0, a_ready}, 32'd1);
      chk("bp_release_b_ready", {31'd0, b_ready}, 32'd0);
      step(0, 0, 0, 0, 1, 0);
      chk("bp_next_y_data", {24'd0, y_data}, 32'hC0);
      chk("bp_next_y_valid", {31'd0, y_valid}, 32'd1);

      // Single requester A, then idle: valid drops, data held.
      step(1, 8'h11, 0, 0, 1, 0);
      chk("solo_a_ready", {31'd0, a_ready}, 32'd1);
      chk("solo_sel", {31'd0, sel}, 32'd0);
      step(0, 0, 0, 0, 1, 0);
      chk("solo_y_data", {24'd0, y_data}, 32'h11);
      chk("solo_y_valid", {31'd0, y_valid}, 32'd1);
      chk("solo_y_src", {31'd0, y_src}, 32'd0);
      step(0, 0, 0, 0, 1, 0);
      chk("idle_y_valid", {31'd0, y_valid}, 32'd0);
      chk("idle_y_data", {24'd0, y_data}, 32'h11);

      // Alternate single requesters.
      for (int n = 0; n < 8; n++) begin
         if (n % 2 == 0) step(1, 8'h20 + n[7:0], 0, 0, 1, 0);
         else            step(0, 0, 1, 8'h30 + n[7:0], 1, 0);
         chk("alt_ready", {31'd0, (n % 2 == 0) ? a_ready : b_ready}, 32'd1);
         if (n > 0) begin
            chk("alt_y_data", {24'd0, y_data},
                ((n - 1) % 2 == 0) ? 32'h20 + n - 1 : 32'h30 + n - 1);
            chk("alt_y_src", {31'd0, y_src}, ((n - 1) % 2 == 0) ? 32'd0 : 32'd1);
         end
      end

      // Randomized traffic, checked every cycle by the model compare.
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
              W'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      end

      step(0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mux2to1_stream_arb
